ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch unit for the single-cycle MIPS core; sits directly downstream of the control decoder's NPCOp output.
- Owns the PC register and computes the next PC from npc_op, zero, the immediates and rs.
- Fetches each instruction from an instruction memory over a request/response handshake.
- Presents one instruction per commit window to decode/execute. instr_valid gates all architectural writes (RegW, MemW).

Parameters:
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- ALIGN_CHECK, 1: when 1, a jr target with ra[1:0]!=0 raises addr_err and halts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- npc_op  in  3  next-PC select from the decoder. 000 seq; 001 beq; 010 j/jal; 011 bne; 100 jr; 101-111 treated as seq.
- zero  in  1  ALU equal flag for the current instruction.
- imm16  in  16  branch offset, instr[15:0].
- imm26  in  26  jump index, instr[25:0].
- ra  in  32  rs register value, used as the jr target.
- stall  in  1  holds the current instruction in the commit window.
- imem_req  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_rsp_valid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered current instruction.
- instr_valid  out  1  commit window for the current instruction.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, the jal link value.
- addr_err  out  1  sticky misaligned-jr error.

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, pc=RESET_PC, instr=0.
  - instr_valid=0, addr_err=0.
  - imem_req is deasserted combinationally while rst_n=0.
- States:
  - REQ: imem_req=1, imem_addr=pc. Go to WAIT on imem_req_ready. imem_rsp_valid is ignored in REQ.
  - WAIT: imem_req=0. On imem_rsp_valid: instr<=imem_rdata, go to EXEC. The response must arrive at least one cycle after acceptance; a same-cycle response is not supported.
  - EXEC: instr_valid=1.
    - stall=1: stay in EXEC; pc and instr hold.
    - stall=0: pc<=next_pc, go to REQ.
  - HALT: entered from EXEC when a misaligned jr is detected. addr_err=1, instr_valid=0, imem_req=0. Only reset leaves HALT.
- Next-PC (combinational, evaluated in EXEC):
  - p4=pc+4 (32-bit, wraps modulo 2^32).
  - seq: p4.
  - beq: zero ? p4+({{14{imm16[15]}},imm16,2'b00}) : p4.
  - bne: !zero ? branch target : p4.
  - j/jal: {p4[31:28],imm26,2'b00}.
  - jr: ra.
- Misaligned jr:
  - Applies when ALIGN_CHECK=1 and npc_op=100 with ra[1:0]!=0.
  - On EXEC exit: pc holds, addr_err<=1, go to HALT.
  - No fetch is issued to the misaligned address.
- Latency: with zero-wait memory (ready in REQ, rsp the next cycle) one instruction takes 3 cycles: REQ, WAIT, EXEC. instr_valid is high for exactly 1 cycle per instruction when stall=0.
- pc_plus4 = pc+4 at all times. It is stable through EXEC for jal link writeback.
- Reset mid-operation: any outstanding imem response is dropped. Instruction memory shares rst_n and must discard in-flight reads.
- Back-pressure: imem_addr and imem_req hold stable while in REQ with imem_req_ready=0.

Decomposition:
- Shared package mips_pkg:
  - NPC_SEQ/BEQ/J/BNE/JR 3-bit constants, matching the decoder encoding.
  - fetch state enum {REQ, WAIT, EXEC, HALT}.
  - Default RESET_PC.
- Sub-module npc_calc: purely combinational next-PC mux. Inputs pc, npc_op, zero, imm16, imm26, ra. Outputs next_pc and misalign.

Test Plan:
- Reset and sequential fetch: rst_n low then high, npc_op=000, zero-wait memory. Required: imem_addr=3000, 3004, 3008 on consecutive REQ cycles, instr_valid pulses every 3rd cycle, pc_plus4=3004 during the first EXEC.
- beq taken/not-taken: pc=3010, imm16=16'hFFFC, npc_op=001. Required: zero=1 gives next pc=3004; zero=0 gives next pc=3014.
- bne and j: pc=3000, npc_op=011, zero=0, imm16=2 gives 300C. npc_op=010 with pc=3000 and imm26=26'h0000C10 gives 00003040.
- jr aligned/misaligned: ra=00003100 gives next pc=3100. ra=00003102 gives addr_err=1, state HALT, imem_req stays 0 for 20 cycles, then rst_n pulse clears addr_err and pc=3000.
- Stall and memory back-pressure: imem_req_ready low 3 cycles gives imem_addr held and req held. stall high 4 cycles in EXEC gives instr_valid high 5 cycles, pc unchanged, one advance afterwards.
- Async reset in WAIT: assert rst_n=0 mid-cycle. Required: outputs reset immediately, a late imem_rsp_valid is ignored, and the next fetch is 3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: decoder NPC encodings, fetch states, reset vector.
package mips_pkg;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_BNE = 3'b011;
  localparam logic [2:0] NPC_JR  = 3'b100;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface ifu_fetch_if;
  logic        imem_req;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rdata
  );
endinterface

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC select for the fetch unit, plus misaligned-jr detection.
module npc_calc
  import mips_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] p4;
  logic [31:0] br_target;

  assign p4        = pc + 32'd4;
  assign br_target = p4 + {{14{imm16[15]}}, imm16, 2'b00};

  // Unused encodings 101-111 fall through to sequential.
  always_comb begin
    next_pc = p4;
    case (npc_op)
      NPC_BEQ: next_pc = zero ? br_target : p4;
      NPC_BNE: next_pc = zero ? p4 : br_target;
      NPC_J:   next_pc = {p4[31:28], imm26, 2'b00};
      NPC_JR:  next_pc = ra;
      default: next_pc = p4;
    endcase
  end

  assign misalign = ALIGN_CHECK && (npc_op == NPC_JR) && (ra[1:0] != 2'b00);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, fetches over the imem handshake and
// presents one instruction per commit window.
//
//   state | meaning
//   REQ   | request outstanding at pc, waiting for imem_req_ready
//   WAIT  | request accepted, waiting for imem_rsp_valid
//   EXEC  | instruction committed (instr_valid), advance pc when not stalled
//   HALT  | misaligned jr seen, frozen until reset
module ifu_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         npc_op,
  input  logic               zero,
  input  logic [15:0]        imm16,
  input  logic [25:0]        imm26,
  input  logic [31:0]        ra,
  input  logic               stall,
  ifu_fetch_if.master        imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         err_q, err_d;
  logic [31:0]  next_pc;
  logic         misalign;

  npc_calc #(.ALIGN_CHECK(ALIGN_CHECK)) u_npc_calc (
    .pc       (pc_q),
    .npc_op   (npc_op),
    .zero     (zero),
    .imm16    (imm16),
    .imm26    (imm26),
    .ra       (ra),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      REQ: begin
        if (imem.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A misaligned jr keeps pc on the offending instruction for debug.
        if (!stall) begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = REQ;
    endcase
  end

  assign imem.imem_req  = rst_n && (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == EXEC);
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign addr_err       = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized
// instruction streams checked against a behavioural next-PC model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic        zero = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] imm26 = 26'd0;
  logic [31:0] ra = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, addr_err;

  int          total = 0;
  int          passed = 0;
  int          last_cycles = 0;
  logic [31:0] exp_pc = 32'h0000_3000;

  ifu_fetch_if imem ();

  ifu_fetch #(.RESET_PC(32'h0000_3000), .ALIGN_CHECK(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc_op      (npc_op),
    .zero        (zero),
    .imm16       (imm16),
    .imm26       (imm26),
    .ra          (ra),
    .stall       (stall),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next PC straight from the ISA rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] op,
                                            input logic z, input logic [15:0] i16,
                                            input logic [25:0] i26, input logic [31:0] r);
    logic [31:0] seq;
    logic [31:0] off;
    seq = cur + 32'd4;
    off = $signed(i16) * 4;
    case (op)
      3'd1:    return z ? seq + off : seq;
      3'd3:    return z ? seq : seq + off;
      3'd2:    return (seq & 32'hF000_0000) + i26 * 4;
      3'd4:    return r;
      default: return seq;
    endcase
  endfunction

  // One full instruction: fetch with back-pressure, response delay, EXEC with stalls.
  task automatic run_instr(input logic [2:0] op, input logic z, input logic [15:0] i16,
                           input logic [25:0] i26, input logic [31:0] r,
                           input int bp, input int dly, input int stl);
    int          cyc = 0;
    int          guard = 0;
    logic [31:0] word;
    logic [31:0] nxt;
    bit          mis;
    word = $urandom;
    while (imem.imem_req !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    total++;
    if (guard >= 20) $display("FAIL req_wait act=no_req exp=req");
    else passed++;
    total++;
    if (imem.imem_addr !== exp_pc) $display("FAIL fetch_addr act=%h exp=%h", imem.imem_addr, exp_pc);
    else passed++;

    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      step();
      cyc++;
      total++;
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== exp_pc)
        $display("FAIL bp_hold act=req%b/%h exp=req1/%h", imem.imem_req, imem.imem_addr, exp_pc);
      else passed++;
    end
    imem.imem_req_ready = 1'b1;
    step();
    cyc++;
    imem.imem_req_ready = 1'b0;
    total++;
    if (imem.imem_req !== 1'b0) $display("FAIL wait_req act=%b exp=0", imem.imem_req);
    else passed++;

    for (int i = 0; i < dly; i++) begin
      step();
      cyc++;
      total++;
      if (instr_valid !== 1'b0) $display("FAIL wait_valid act=%b exp=0", instr_valid);
      else passed++;
    end
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rdata     = word;
    step();
    cyc++;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rdata     = $urandom;

    total++;
    if (instr_valid !== 1'b1 || instr !== word)
      $display("FAIL exec_instr act=v%b/%h exp=v1/%h", instr_valid, instr, word);
    else passed++;
    total++;
    if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4)
      $display("FAIL exec_pc act=%h/%h exp=%h/%h", pc, pc_plus4, exp_pc, exp_pc + 32'd4);
    else passed++;

    npc_op = op; zero = z; imm16 = i16; imm26 = i26; ra = r;
    stall  = (stl > 0);
    for (int i = 0; i < stl; i++) begin
      step();
      cyc++;
      total++;
      if (instr_valid !== 1'b1 || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4)
        $display("FAIL stall_hold act=v%b/%h exp=v1/%h", instr_valid, pc, exp_pc);
      else passed++;
    end
    stall = 1'b0;
    mis = (op == 3'd4) && (r[1:0] != 2'b00);
    nxt = ref_next(exp_pc, op, z, i16, i26, r);
    step();
    cyc++;
    last_cycles = cyc;
    total++;
    if (instr_valid !== 1'b0) $display("FAIL valid_pulse act=%b exp=0", instr_valid);
    else passed++;
    if (mis) begin
      total++;
      if (addr_err !== 1'b1 || imem.imem_req !== 1'b0 || pc !== exp_pc)
        $display("FAIL halt_entry act=err%b/req%b/%h exp=err1/req0/%h", addr_err, imem.imem_req, pc, exp_pc);
      else passed++;
    end else begin
      total++;
      if (addr_err !== 1'b0) $display("FAIL addr_err act=%b exp=0", addr_err);
      else passed++;
      exp_pc = nxt;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rdata     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || addr_err !== 1'b0)
      $display("FAIL reset_ctrl act=req%b/v%b/e%b exp=0/0/0", imem.imem_req, instr_valid, addr_err);
    else passed++;
    total++;
    if (pc !== 32'h3000 || instr !== 32'd0 || pc_plus4 !== 32'h3004)
      $display("FAIL reset_regs act=%h/%h/%h exp=3000/0/3004", pc, instr, pc_plus4);
    else passed++;
    rst_n  = 1'b1;
    exp_pc = 32'h3000;
  endtask

  task automatic test_seq();
    for (int k = 0; k < 3; k++) begin
      run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, 0, 0);
      total++;
      if (last_cycles !== 3) $display("FAIL seq_latency act=%0d exp=3", last_cycles);
      else passed++;
    end
    total++;
    if (imem.imem_addr !== 32'h300C) $display("FAIL seq_addr act=%h exp=0000300c", imem.imem_addr);
    else passed++;
  endtask

  task automatic test_branches();
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3010, 0, 0, 0);
    run_instr(3'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0, 0, 0, 0);
    total++;
    if (imem.imem_addr !== 32'h3004) $display("FAIL beq_taken act=%h exp=00003004", imem.imem_addr);
    else passed++;
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3010, 0, 0, 0);
    run_instr(3'd1, 1'b0, 16'hFFFC, 26'd0, 32'd0, 0, 0, 0);
    total++;
    if (imem.imem_addr !== 32'h3014) $display("FAIL beq_not_taken act=%h exp=00003014", imem.imem_addr);
    else passed++;
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3000, 0, 0, 0);
    run_instr(3'd3, 1'b0, 16'd2, 26'd0, 32'd0, 0, 0, 0);
    total++;
    if (imem.imem_addr !== 32'h300C) $display("FAIL bne_taken act=%h exp=0000300c", imem.imem_addr);
    else passed++;
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3000, 0, 0, 0);
    run_instr(3'd2, 1'b0, 16'd0, 26'h0000C10, 32'd0, 0, 0, 0);
    total++;
    if (imem.imem_addr !== 32'h3040) $display("FAIL jump act=%h exp=00003040", imem.imem_addr);
    else passed++;
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3100, 0, 0, 0);
    total++;
    if (imem.imem_addr !== 32'h3100) $display("FAIL jr_aligned act=%h exp=00003100", imem.imem_addr);
    else passed++;
  endtask

  task automatic test_backpressure_stall();
    logic [31:0] base;
    base = exp_pc;
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 3, 0, 4);
    total++;
    if (last_cycles !== 10) $display("FAIL bp_stall_cycles act=%0d exp=10", last_cycles);
    else passed++;
    total++;
    if (imem.imem_addr !== base + 32'd4) $display("FAIL stall_advance act=%h exp=%h", imem.imem_addr, base + 32'd4);
    else passed++;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] r;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      r  = $urandom & 32'hFFFF_FFFC;
      run_instr(op, 1'($urandom_range(0, 1)), 16'($urandom), 26'($urandom), r,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3) == 0 ? 1 : 0);
    end
  endtask

  task automatic test_halt();
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3100, 0, 0, 0);
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3102, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (imem.imem_req !== 1'b0 || addr_err !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h3100)
        $display("FAIL halt_hold act=req%b/e%b/v%b/%h exp=req0/e1/v0/00003100",
                 imem.imem_req, addr_err, instr_valid, pc);
      else passed++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (addr_err !== 1'b0 || pc !== 32'h3000) $display("FAIL halt_reset act=e%b/%h exp=e0/00003000", addr_err, pc);
    else passed++;
    step();
    rst_n  = 1'b1;
    exp_pc = 32'h3000;
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    run_instr(3'd4, 1'b0, 16'd0, 26'd0, 32'h3100, 0, 0, 0);
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (imem.imem_req !== 1'b0 || pc !== 32'h3000 || instr !== 32'd0 || instr_valid !== 1'b0)
      $display("FAIL async_reset act=req%b/%h/%h/v%b exp=req0/00003000/0/v0", imem.imem_req, pc, instr, instr_valid);
    else passed++;
    step();
    rst_n = 1'b1;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rdata     = 32'hDEAD_BEEF;
    step();
    imem.imem_rsp_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h3000)
      $display("FAIL late_rsp act=v%b/req%b/%h exp=v0/req1/00003000", instr_valid, imem.imem_req, imem.imem_addr);
    else passed++;
    exp_pc = 32'h3000;
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branches();
    test_backpressure_stall();
    test_random();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
